// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read / 1-write general-purpose register file.
// r0 reads as zero; optional same-cycle write-to-read forwarding.
module regfile_2r1w #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  WD,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_en;

  assign wr_en = WE && (WA != '0);

  // Next array state: clear beats write; r0 is never written
  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en) begin
      regs_d[WA] = WD;
    end
  end

  // Storage flops
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Port 1 read: array, then forward pending write, r0 forced to zero
  always_comb begin
    RD1 = regs_q[RA1];
    if (BYPASS != 0 && wr_en && WA == RA1) begin
      RD1 = WD;
    end
    if (RA1 == '0) begin
      RD1 = '0;
    end
  end

  // Port 2 read: same rules as port 1
  always_comb begin
    RD2 = regs_q[RA2];
    if (BYPASS != 0 && wr_en && WA == RA2) begin
      RD2 = WD;
    end
    if (RA2 == '0) begin
      RD2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed + random bench for regfile_2r1w.
// Runs a forwarding and a non-forwarding instance off shared inputs.
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic [4:0]  RA1, RA2, WA;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  typedef struct {
    logic [31:0] e1b;
    logic [31:0] e2b;
    logic [31:0] e1n;
    logic [31:0] e2n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail = 0;

  regfile_2r1w #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2),
    .WE(WE), .WA(WA), .WD(WD), .RD1(rd1_b), .RD2(rd2_b)
  );

  regfile_2r1w #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2),
    .WE(WE), .WA(WA), .WD(WD), .RD1(rd1_n), .RD2(rd2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(logic [4:0] ra, bit byp);
    if (ra == 5'd0) return 32'd0;
    if (byp && WE === 1'b1 && WA == ra) return WD;
    return model[ra];
  endfunction

  task automatic drive(bit r, bit we, logic [4:0] wa,
                       logic [31:0] wd, logic [4:0] ra1,
                       logic [4:0] ra2);
    reset = r;
    WE    = we;
    WA    = wa;
    WD    = wd;
    RA1   = ra1;
    RA2   = ra2;
  endtask

  task automatic check(string tag);
    exp_t e;
    e.e1b = exp_rd(RA1, 1'b1);
    e.e2b = exp_rd(RA2, 1'b1);
    e.e1n = exp_rd(RA1, 1'b0);
    e.e2n = exp_rd(RA2, 1'b0);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_checks++;
    assert (rd1_b === e.e1b) else begin
      n_fail++;
      $error("FAIL %s byp.RD1 ra=%0d observed %h expected %h",
             tag, RA1, rd1_b, e.e1b);
    end
    n_checks++;
    assert (rd2_b === e.e2b) else begin
      n_fail++;
      $error("FAIL %s byp.RD2 ra=%0d observed %h expected %h",
             tag, RA2, rd2_b, e.e2b);
    end
    n_checks++;
    assert (rd1_n === e.e1n) else begin
      n_fail++;
      $error("FAIL %s nob.RD1 ra=%0d observed %h expected %h",
             tag, RA1, rd1_n, e.e1n);
    end
    n_checks++;
    assert (rd2_n === e.e2n) else begin
      n_fail++;
      $error("FAIL %s nob.RD2 ra=%0d observed %h expected %h",
             tag, RA2, rd2_n, e.e2n);
    end
    n_checks++;
    assert (reset === 1'b1 || !$isunknown(WE)) else begin
      n_fail++;
      $error("FAIL %s we_x observed %b expected 0/1", tag, WE);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (WE === 1'b1 && WA != 5'd0) begin
      model[WA] = WD;
    end
    #1;
  endtask

  task automatic check_all(string tag);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      check(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    drive(1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    tick();
    tick();

    // reset clears a written register
    drive(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    tick();
    drive(0, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("rst_pre");
    drive(1, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    tick();
    check("rst_clear");
    // write under reset: forward shows WD, nothing stored
    drive(1, 1, 5'd5, 32'h1234, 5'd5, 5'd5);
    check("rst_wr_fwd");
    tick();
    drive(0, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("rst_wr_drop");

    // r0 immutable
    drive(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("r0_pre");
    tick();
    check("r0_post");

    // fill r1..r31, then cross sweep
    for (int n = 1; n < 32; n++) begin
      drive(0, 1, 5'(n), 32'h1000 + n, 5'd0, 5'd0);
      tick();
    end
    check_all("sweep");

    // forwarding vs no forwarding
    drive(0, 1, 5'd7, 32'h11, 5'd0, 5'd0);
    tick();
    drive(0, 1, 5'd7, 32'h22, 5'd7, 5'd7);
    check("byp_pre");
    tick();
    check("byp_post");

    // back-to-back writes to r3
    drive(0, 1, 5'd3, 32'hA, 5'd3, 5'd4);
    tick();
    check("b2b_n");
    drive(0, 1, 5'd3, 32'hB, 5'd3, 5'd4);
    check("b2b_pre");
    tick();
    check("b2b_n1");
    check_all("b2b_all");

    // WE=0 hold
    drive(0, 1, 5'd9, 32'h99, 5'd0, 5'd0);
    tick();
    drive(0, 0, 5'd9, 32'h55, 5'd9, 5'd9);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold");
    end

    // random run against the model
    for (int c = 0; c < 1000; c++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
            wa, $urandom,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      check("rand_pre");
      tick();
    end
    check_all("rand_all");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
